// File: rtl/uart_host_tx.sv
// uart_host_tx: byte-FIFO fed UART transmitter, LSB first, 8N1/8N2 by default.
// Optional feature macro: UART_TX_PARITY_EN adds one even-parity bit after
// data bit 7 (8E1/8E2). Without it the PARITY state is not compiled in.
// Frames are emitted back-to-back while the FIFO holds data.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high, waiting for a byte in the FIFO
// START  | line low for one bit cell
// DATA   | shifting out 8 data bits, LSB first
// PARITY | even parity of the byte, one bit cell (macro only)
// STOP   | line high for STOP_BITS cells, then pop next byte or idle
module uart_host_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL      = FIFO_DEPTH[AW:0];

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    // FIFO storage and pointers
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic [7:0]    rd_data;
    logic          push;
    logic          pop;

    // transmitter state
    logic [2:0]    state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          busy_n;
    logic          cell_end;
`ifdef UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    assign din_ready  = (count != FULL);
    assign push       = din_valid && din_ready && !rst;
    assign rd_data    = mem[rd_ptr];
    assign fifo_count = count;
    assign cell_end   = (baud == BAUD_LAST);

    // next-state logic: bit-cell sequencing, and pop from the FIFO head
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        if (state != S_IDLE && !cell_end) begin
            baud_n = baud + 1'b1;
        end
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (count != '0) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (cell_end) begin
                    baud_n  = '0;
                    state_n = S_DATA;
                    tx_n    = shift[0];
                end
            end
            S_DATA: begin
                if (cell_end) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        tx_n    = par;
`else
                        state_n = S_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_n = bit_idx + 1'b1;
                        tx_n  = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cell_end) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cell_end) begin
                    baud_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_n = '0;
                        if (count != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
        // shift register is loaded only here, so later pushes never touch a frame in flight
        if (pop) begin
            state_n = S_START;
            baud_n  = '0;
            bit_n   = '0;
            shift_n = rd_data;
            tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_n   = ^rd_data;
`endif
        end
    end

    // occupancy after this edge; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + 1'b1;
        end else if (pop && !push) begin
            count_n = count - 1'b1;
        end
        busy_n = (state_n != S_IDLE) || (count_n != '0);
    end

    // FIFO data array; no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
        end
    end

    // transmitter registers, including registered tx and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_host_tx.sv
// tb_uart_host_tx: directed bench for uart_host_tx with a byte scoreboard.
// A line monitor decodes every frame, checks cell timing and compares the
// byte against the queue filled when the push was accepted.
module tb_uart_host_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NCELL = 1 + 8 + PAR + STOPB;
    localparam int FRAME = NCELL * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int frames_seen = 0;
    int last_cnt = 0;
    int last_wait = 0;
    logic [7:0] q[$];
    int gaps_q[$];

    uart_host_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // offer one byte, hold until accepted; returns just after the accepting edge
    task automatic push(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        din = b;
        din_valid = 1'b1;
        while (!din_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        last_wait = t;
        if (!din_ready) begin
            chk("push_timeout", {31'd0, din_ready}, 32'd1);
        end else begin
            @(posedge clk);
            q.push_back(b);
            #1;
            last_cnt = int'(fifo_count);
        end
    endtask

    task automatic release_valid();
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_queue", q.size(), 32'd0);
    endtask

    // line monitor: capture each frame at negedges and score it
    initial begin : monitor
        logic       samp [FRAME];
        logic [7:0] b;
        logic [8:0] exp9;
        logic       ok;
        logic       aborted;
        int         gap;
        gap = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap = 0;
            end else if (tx === 1'b0) begin
                samp[0] = tx;
                aborted = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                    samp[i] = tx;
                end
                if (!aborted) begin
                    ok = 1'b1;
                    for (int c = 0; c < NCELL; c++) begin
                        for (int j = 1; j < CPB; j++) begin
                            if (samp[c*CPB+j] !== samp[c*CPB]) ok = 1'b0;
                        end
                    end
                    if (samp[0] !== 1'b0) ok = 1'b0;
                    for (int c = 9 + PAR; c < NCELL; c++) begin
                        if (samp[c*CPB] !== 1'b1) ok = 1'b0;
                    end
                    for (int k = 0; k < 8; k++) b[k] = samp[(1+k)*CPB];
                    chk("frame_shape", {31'd0, ok}, 32'd1);
`ifdef UART_TX_PARITY_EN
                    chk("frame_parity", {31'd0, samp[9*CPB]}, {31'd0, ^b});
`endif
                    exp9 = (q.size() != 0) ? {1'b0, q.pop_front()} : 9'h100;
                    chk("frame_byte", {23'd0, 1'b0, b}, {23'd0, exp9});
                    frames_seen++;
                    gaps_q.push_back(gap);
                end
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    initial begin : stim
        int f0;
        int mx;
        logic [7:0] b;

        // reset held 3 cycles with a push offered
        din = 8'hAA;
        din_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_ready", {31'd0, din_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("rst_no_frame", frames_seen, 32'd0);
        chk("rst_tx_idle", {31'd0, tx}, 32'd1);

        // single byte 0x55: start one cycle after acceptance, busy after 40
        f0 = frames_seen;
        push(8'h55);
        @(negedge clk);
        din_valid = 1'b0;
        chk("tx_before_pop", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("tx_start_fall", {31'd0, tx}, 32'd0);
        repeat (39) @(negedge clk);
        chk("busy_last_stop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        wait_idle();
        chk("single_frames", frames_seen - f0, 32'd1);

        // back-to-back: four consecutive pushes, a fifth fills, a sixth waits for a pop
        f0 = frames_seen;
        gaps_q.delete();
        push(8'h00);
        chk("b2b_ready1", {31'd0, din_ready}, 32'd1);
        push(8'hFF);
        chk("b2b_ready2", {31'd0, din_ready}, 32'd1);
        push(8'hA5);
        chk("b2b_ready3", {31'd0, din_ready}, 32'd1);
        push(8'h3C);
        chk("b2b_ready4", {31'd0, din_ready}, 32'd1);
        chk("b2b_count4", last_cnt, 32'd3);
        push(8'h81);
        chk("b2b_full_ready", {31'd0, din_ready}, 32'd0);
        chk("b2b_full_count", last_cnt, 32'd4);
        push(8'h5A);
        chk("b2b_push6_wait", last_wait, 32'd37);
        chk("b2b_push6_count", last_cnt, 32'd4);
        release_valid();
        wait_idle();
        chk("b2b_frames", frames_seen - f0, 32'd6);
        chk("b2b_gap_count", gaps_q.size(), 32'd6);
        for (int i = 1; i < 6; i++) begin
            if (i < gaps_q.size()) chk("b2b_gap", gaps_q[i], 32'd0);
        end

        // FIFO full: valid held across 8 pushes, nothing lost or duplicated
        f0 = frames_seen;
        mx = 0;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            if (last_cnt > mx) mx = last_cnt;
            chk("full_ready_vs_count", {31'd0, din_ready}, {31'd0, (last_cnt != DEPTH)});
        end
        release_valid();
        chk("full_max_count", mx, 32'd4);
        wait_idle();
        chk("full_frames", frames_seen - f0, 32'd8);

`ifdef UART_TX_PARITY_EN
        // parity: 0x07 carries an even-parity bit of 1
        f0 = frames_seen;
        push(8'h07);
        release_valid();
        wait_idle();
        chk("parity_frames", frames_seen - f0, 32'd1);
`endif

        // reset during data bit 3 of 0xC3 with two more bytes queued
        push(8'hC3);
        push(8'h11);
        push(8'h22);
        release_valid();
        repeat (16) @(negedge clk);
        chk("mid_tx_bit3", {31'd0, tx}, 32'd0);
        chk("mid_count", {29'd0, fifo_count}, 32'd2);
        f0 = frames_seen;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("mid_no_frame", frames_seen - f0, 32'd0);
        chk("mid_tx_idle", {31'd0, tx}, 32'd1);
        chk("mid_busy_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
